// File: rtl/bp_pkg.sv
// Shared definitions for the branch prediction slice.
// Holds the direction encodings, the default sizing constants, and the
// training bundle that the resolver sends back to the 2-bit direction
// predictor. The predictor uses the same bundle type.
package bp_pkg;

    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    // Training strobe to the predictor: result marks a valid update and
    // taken carries the actual branch direction.
    typedef struct packed {
        logic result;
        logic taken;
    } bp_update_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with an enable input.
// Once the count reaches all-ones it stays there until reset.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears the count
//   en    - increment request for this cycle
//   count - current registered count
module bp_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment only while the count is below its ceiling.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: queues issued direction predictions in order and checks
// each one against the actual outcome when the oldest branch resolves.
// Ports:
//   clk, rst_n                  - clock and asynchronous active-low reset
//   pred_valid, pred_taken      - prediction issue (push)
//   pred_ready                  - queue not full
//   resolve_valid, resolve_taken- oldest branch resolves (pop)
//   upd_result, upd_taken       - one-cycle predictor training strobe
//   mispredict                  - one-cycle pulse on a wrong prediction
//   resolve_err                 - one-cycle pulse on a resolve with an empty queue
//   overflow                    - sticky, a push was attempted while full
//   occupancy                   - entries currently queued
//   branch_cnt, mispred_cnt     - saturating statistics counters
module branch_resolver
    import bp_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic                       upd_result,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic                       resolve_err,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           branch_cnt,
    output logic [CNT_W-1:0]           mispred_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    bp_update_t       upd_q, upd_d;
    logic             mispredict_q, mispredict_d;
    logic             resolve_err_q, resolve_err_d;
    logic             overflow_q, overflow_d;

    logic empty;
    logic full;
    logic head;
    logic pop;
    logic miss;
    logic push;

    // The extra pointer MSB separates a full queue from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign head  = fifo_q[rd_ptr_q[IDX_W-1:0]];

    assign pop  = resolve_valid && !empty;
    assign miss = pop && (head != resolve_taken);
    // A push coinciding with a mispredict is wrong-path and is discarded.
    assign push = pred_valid && !full && !miss;

    always_comb begin
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        upd_d.result  = pop;
        upd_d.taken   = pop ? resolve_taken : NOT_TAKEN;
        mispredict_d  = miss;
        resolve_err_d = resolve_valid && empty;
        overflow_d    = overflow_q | (pred_valid && full && !miss);

        if (push) begin
            fifo_d[wr_ptr_q[IDX_W-1:0]] = pred_taken;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        // A misprediction flushes every younger entry along with the head.
        if (miss) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            upd_q         <= '{result: 1'b0, taken: NOT_TAKEN};
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            upd_q         <= upd_d;
            mispredict_q  <= mispredict_d;
            resolve_err_q <= resolve_err_d;
            overflow_q    <= overflow_d;
        end
    end

    // Statistics advance on the same edge that raises the training strobe.
    bp_sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pop),
        .count (branch_cnt)
    );

    bp_sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (miss),
        .count (mispred_cnt)
    );

    assign pred_ready  = !full;
    assign occupancy   = OCC_W'(wr_ptr_q - rd_ptr_q);
    assign upd_result  = upd_q.result;
    assign upd_taken   = upd_q.taken;
    assign mispredict  = mispredict_q;
    assign resolve_err = resolve_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver. Two instances share the same
// stimulus: the default 16-bit-counter build and a 4-bit-counter build
// whose statistics saturate quickly. Both are compared every cycle against
// a queue-based reference model.
module tb_branch_resolver;

    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH+1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pred_valid = 1'b0;
    logic pred_taken = 1'b0;
    logic resolve_valid = 1'b0;
    logic resolve_taken = 1'b0;

    logic             pred_ready, upd_result, upd_taken, mispredict, resolve_err, overflow;
    logic [OCC_W-1:0] occupancy;
    logic [15:0]      branch_cnt, mispred_cnt;

    logic             s_pred_ready, s_upd_result, s_upd_taken, s_mispredict, s_resolve_err, s_overflow;
    logic [OCC_W-1:0] s_occupancy;
    logic [3:0]       s_branch_cnt, s_mispred_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit model_q[$];
    bit exp_upd, exp_taken, exp_mis, exp_err, exp_ovf;
    int n_branch, n_mis;

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .upd_result(upd_result), .upd_taken(upd_taken), .mispredict(mispredict),
        .resolve_err(resolve_err), .overflow(overflow), .occupancy(occupancy),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(s_pred_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .upd_result(s_upd_result), .upd_taken(s_upd_taken), .mispredict(s_mispredict),
        .resolve_err(s_resolve_err), .overflow(s_overflow), .occupancy(s_occupancy),
        .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int satTo(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    // Compare every output of both builds with the model.
    task automatic checkAll();
        checkOutput("pred_ready",  {31'd0, pred_ready},  {31'd0, model_q.size() < DEPTH});
        checkOutput("upd_result",  {31'd0, upd_result},  {31'd0, exp_upd});
        checkOutput("upd_taken",   {31'd0, upd_taken},   {31'd0, exp_taken});
        checkOutput("mispredict",  {31'd0, mispredict},  {31'd0, exp_mis});
        checkOutput("resolve_err", {31'd0, resolve_err}, {31'd0, exp_err});
        checkOutput("overflow",    {31'd0, overflow},    {31'd0, exp_ovf});
        checkOutput("occupancy",   32'(occupancy),       32'(model_q.size()));
        checkOutput("branch_cnt",  32'(branch_cnt),      32'(satTo(n_branch, 65535)));
        checkOutput("mispred_cnt", 32'(mispred_cnt),     32'(satTo(n_mis, 65535)));
        checkOutput("s_occupancy", 32'(s_occupancy),     32'(model_q.size()));
        checkOutput("s_overflow",  {31'd0, s_overflow},  {31'd0, exp_ovf});
        checkOutput("s_upd_result",{31'd0, s_upd_result},{31'd0, exp_upd});
        checkOutput("s_branch_cnt",32'(s_branch_cnt),    32'(satTo(n_branch, 15)));
        checkOutput("s_mispred_cnt",32'(s_mispred_cnt),  32'(satTo(n_mis, 15)));
    endtask

    task automatic modelReset();
        model_q.delete();
        exp_upd = 0; exp_taken = 0; exp_mis = 0; exp_err = 0; exp_ovf = 0;
        n_branch = 0; n_mis = 0;
    endtask

    // One clock of stimulus; the model advances at the edge, checks run 1ns later.
    task automatic applyStimulus(input bit pv, input bit pt, input bit rv, input bit rt);
        int  sz0;
        bit  pop, miss;
        pred_valid = pv; pred_taken = pt; resolve_valid = rv; resolve_taken = rt;
        @(posedge clk);
        sz0 = model_q.size();
        pop = rv && (sz0 > 0);
        miss = 0;
        exp_upd = pop; exp_taken = pop ? rt : 0; exp_err = rv && (sz0 == 0);
        if (pop) begin
            miss = (model_q.pop_front() != rt);
            n_branch++;
            if (miss) begin
                n_mis++;
                model_q.delete();
            end
        end
        exp_mis = miss;
        if (pv && !miss) begin
            if (sz0 == DEPTH) exp_ovf = 1;
            else model_q.push_back(pt);
        end
        #1;
        pred_valid = 0; resolve_valid = 0;
        checkAll();
    endtask

    task automatic push(input bit t);
        applyStimulus(1, t, 0, 0);
    endtask

    task automatic resolve(input bit t);
        applyStimulus(0, 0, 1, t);
    endtask

    // Resolve the head with its predicted direction so no flush happens.
    task automatic resolveOk();
        applyStimulus(0, 0, 1, model_q.size() > 0 ? model_q[0] : 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 0;
        modelReset();
        #1;
        checkAll();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        modelReset();
        #1;
        checkAll();
        doReset();

        // In-order correct resolution
        push(1); push(0); push(1);
        resolve(1); resolve(0); resolve(1);
        applyStimulus(0, 0, 0, 0);

        // Mispredict flush, then resolve on empty
        doReset();
        push(1); push(1); push(0);
        resolve(0);
        resolve(1);
        applyStimulus(0, 0, 0, 0);

        // Overflow and in-order drain
        doReset();
        for (int i = 0; i < 5; i++) push(i[0]);
        for (int i = 0; i < 4; i++) resolveOk();
        applyStimulus(0, 0, 0, 0);

        // Full queue with push plus correct resolve in the same cycle
        doReset();
        for (int i = 0; i < 4; i++) push(1);
        applyStimulus(1, 0, 1, 1);
        // Full queue with push plus mispredicting resolve: overflow stays clear
        doReset();
        for (int i = 0; i < 4; i++) push(0);
        applyStimulus(1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);

        // Asynchronous reset with two entries in flight and a strobe active
        doReset();
        push(1); push(0);
        applyStimulus(1, 1, 1, 1);
        #3;
        rst_n = 0;
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rst_n = 1;
        push(0);
        resolve(0);
        applyStimulus(0, 0, 0, 0);

        // Counter saturation on the 4-bit build
        doReset();
        for (int i = 0; i < 20; i++) begin
            push(1);
            resolve(0);
        end

        // Randomized traffic, mostly correct resolves
        doReset();
        for (int i = 0; i < 400; i++) begin
            bit pv, pt, rv, rt;
            pv = ($urandom_range(0, 99) < 55);
            pt = $urandom_range(0, 1);
            rv = ($urandom_range(0, 99) < 45);
            if (model_q.size() > 0 && $urandom_range(0, 3) != 0) rt = model_q[0];
            else rt = $urandom_range(0, 1);
            applyStimulus(pv, pt, rv, rt);
            if ($urandom_range(0, 199) == 0) doReset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Sits directly downstream of the 2-bit saturating direction predictor.
- Queues each issued prediction in order and compares it with the actual branch outcome when the branch resolves.
- Generates the predictor's training strobe (result/taken) and a misprediction pulse that flushes the in-flight queue.
- Maintains saturating statistics counters for total resolved branches and mispredictions.

Parameters:
- DEPTH, 4, maximum in-flight unresolved predictions; power of two, ≥2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pred_valid  in  1  a prediction is issued this cycle
- pred_taken  in  1  predicted direction (1 = taken)
- pred_ready  out  1  queue can accept a push; equals !full
- resolve_valid  in  1  oldest in-flight branch resolves this cycle
- resolve_taken  in  1  actual direction
- upd_result  out  1  one-cycle training strobe to predictor
- upd_taken  out  1  actual direction accompanying upd_result
- mispredict  out  1  one-cycle pulse; prediction ≠ outcome
- resolve_err  out  1  one-cycle pulse; resolve on empty queue
- overflow  out  1  sticky; push attempted while full
- occupancy  out  $clog2(DEPTH+1)  entries in queue
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispred_cnt  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset (async, rst_n=0):
  - queue empty; rd/wr pointers = 0; occupancy = 0; pred_ready = 1.
  - upd_result, upd_taken, mispredict, resolve_err, overflow = 0; both counters = 0.
  - Reset mid-operation discards all in-flight entries; no update strobe is emitted for them.
- Storage: circular FIFO of DEPTH 1-bit entries. Pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty; wrap is natural modulo.
- Push: pred_valid && !full → write pred_taken at wr_ptr, wr_ptr++.
  - pred_valid && full → no write; overflow set (sticky until reset).
- Pop: resolve_valid && !empty → read head, rd_ptr++.
  - Next cycle, for exactly one cycle: upd_result = 1, upd_taken = resolve_taken, mispredict = (head != resolve_taken).
  - Latency is 1 cycle, all outputs registered.
- Resolve on empty: no pop, no upd_result; resolve_err = 1 for one cycle; counters unchanged.
- Mispredict flush: on the resolving edge where head != resolve_taken, the whole queue is cleared (rd_ptr = wr_ptr); younger entries are wrong-path.
  - A push in that same cycle is dropped (wrong-path) and does not set overflow.
  - occupancy = 0 the next cycle.
- Simultaneous push and correct pop, not full: both occur; occupancy unchanged.
- Push when full with a simultaneous pop: push refused (pred_ready already 0); overflow set.
- Counters, updated on the same edge that sets upd_result:
  - branch_cnt += 1.
  - mispred_cnt += 1 when mispredicting.
  - Both saturate at all-ones and never wrap.
- occupancy = wr_ptr − rd_ptr (registered pointers).
- pred_ready is combinational from registered pointers only; no input→output path.

Decomposition:
- Shared package bp_pkg:
  - localparam TAKEN = 1'b1, NOT_TAKEN = 1'b0.
  - Default DEPTH and CNT_W constants.
  - Typedef for the predictor training bundle {result, taken}, also reused by the predictor.
- One natural sub-module: bp_sat_counter (CNT_W-wide saturating incrementer with enable), instantiated twice.

Test Plan:
- Reset then 3 pushes (1,0,1), resolves (1,0,1) → 3 upd_result pulses, upd_taken 1,0,1, mispredict never, branch_cnt = 3, mispred_cnt = 0, occupancy 0.
- Pushes (1,1,0); resolve 0 on first → mispredict pulse next cycle, occupancy 0, mispred_cnt = 1, branch_cnt = 1; a following resolve → resolve_err, no upd_result.
- DEPTH=4: 5 consecutive pushes → pred_ready = 0 after 4th, 5th dropped, overflow = 1; 4 correct resolves drain in order, overflow stays 1.
- Full queue plus push and correct resolve in the same cycle → push refused, occupancy 3, overflow = 1; mispredicting resolve plus push in the same cycle → push dropped, occupancy 0, overflow unchanged.
- Assert rst_n low asynchronously mid-stream with 2 entries in flight → outputs 0 immediately, no update strobe; after release a fresh push/resolve works.
- Force CNT_W=4, run 20 mispredicting single-entry pairs → branch_cnt and mispred_cnt hold at 15, no wrap.
